// File: rtl/seg_scroll.sv
// -----------------------------------------------------------------------------
// seg_scroll
//
// Multiplexed common-anode 7-segment hex display driver with a static mode and
// a right-to-left scrolling mode. One digit is enabled at a time; a scan
// divider steps the active digit and a scroll divider steps the scroll
// position through a strip of NIBBLES hex digits followed by DIGITS blanks.
//
// Parameters:
//   DIGITS     - number of physical digits (2..8)
//   NIBBLES    - hex digits in data (DIGITS..16)
//   SCAN_DIV   - clk cycles per digit-scan step
//   SCROLL_DIV - clk cycles per scroll step
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   data       in   value to display, nibble NIBBLES-1 most significant
//   mode       in   0 = static (live data), 1 = scroll (shadowed data)
//   pause      in   1 freezes scroll position and scroll divider
//   sel        out  digit enables, active-low, bit 0 = rightmost digit
//   segments   out  segment drives, active-low, bit 0 = a .. bit 6 = g
//   frame_done out  one-cycle pulse when the scroll position wraps to 0
//
// Build option:
//   SEG_LZB_EN - when defined, static mode blanks leading zeros (digit 0 is
//                always shown). Scroll mode is unaffected.
// -----------------------------------------------------------------------------
module seg_scroll #(
    parameter int DIGITS     = 4,
    parameter int NIBBLES    = 8,
    parameter int SCAN_DIV   = 400000,
    parameter int SCROLL_DIV = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NIBBLES-1:0] data,
    input  logic                 mode,
    input  logic                 pause,
    output logic [DIGITS-1:0]    sel,
    output logic [6:0]           segments,
    output logic                 frame_done
);

    localparam int STRIP_LEN = NIBBLES + DIGITS;
    localparam int SC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RC_W      = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int DW        = $clog2(DIGITS);
    localparam int PW        = $clog2(STRIP_LEN);

    localparam logic [SC_W-1:0] SC_LAST    = SC_W'(SCAN_DIV - 1);
    localparam logic [RC_W-1:0] RC_LAST    = RC_W'(SCROLL_DIV - 1);
    localparam logic [DW-1:0]   D_LAST     = DW'(DIGITS - 1);
    localparam logic [PW-1:0]   P_LAST     = PW'(STRIP_LEN - 1);
    localparam logic [PW-1:0]   P_NIBBLES  = PW'(NIBBLES);
    localparam logic [PW:0]     STRIP_EXT  = (PW+1)'(STRIP_LEN);
    localparam logic [PW:0]     POS_OFFSET = (PW+1)'(NIBBLES + DIGITS - 1);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Active-high hex glyph, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Nibble idx of a data-width word (idx 0 = least significant).
    function automatic logic [3:0] nibble_at(input logic [4*NIBBLES-1:0] word,
                                             input int idx);
        logic [3:0] n;
        n = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (i == idx) begin
                n = word[4*i +: 4];
            end
        end
        return n;
    endfunction

`ifdef SEG_LZB_EN
    // A digit is a leading zero when it lies above the highest non-zero
    // displayed nibble. Digit 0 can never be above that index, so a zero
    // value still shows a single "0".
    function automatic logic leading_zero(input logic [4*NIBBLES-1:0] word,
                                          input int digit);
        int top;
        top = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (word[4*i +: 4] != 4'h0) begin
                top = i;
            end
        end
        return digit > top;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SC_W-1:0]      sc;
    logic [DW-1:0]        d;
    logic [RC_W-1:0]      rc;
    logic [PW-1:0]        p;
    logic [4*NIBBLES-1:0] shadow;
    logic                 mode_q;
    logic                 init_done;

    logic scan_tick;
    logic mode_rise;
    logic scroll_run;
    logic scroll_tick;
    logic wrap;
    logic capture;

    assign scan_tick   = (sc == SC_LAST);
    assign mode_rise   = mode & ~mode_q;
    // The entry cycle into scroll mode only clears the scroll state; counting
    // starts on the following cycle.
    assign scroll_run  = mode & ~mode_rise & ~pause;
    assign scroll_tick = scroll_run & (rc == RC_LAST);
    assign wrap        = scroll_tick & (p == P_LAST);
    // The shadow is loaded on the first clock after reset, on entry into
    // scroll mode and at the end of every pass, so a pass never tears.
    assign capture     = ~init_done | mode_rise | wrap;

    // Digit scan divider and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= '0;
            d  <= '0;
        end else if (scan_tick) begin
            sc <= '0;
            d  <= (d == D_LAST) ? '0 : d + 1'b1;
        end else begin
            sc <= sc + 1'b1;
        end
    end

    // Scroll divider and position. Static mode holds both at zero, which also
    // covers the restart behaviour on either mode edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc         <= '0;
            p          <= '0;
            mode_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            mode_q     <= mode;
            frame_done <= wrap;
            if (!mode || mode_rise) begin
                rc <= '0;
                p  <= '0;
            end else if (scroll_run) begin
                if (scroll_tick) begin
                    rc <= '0;
                    p  <= wrap ? '0 : p + 1'b1;
                end else begin
                    rc <= rc + 1'b1;
                end
            end
        end
    end

    // Shadow copy of data used by scroll mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (capture) begin
                shadow <= data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 0: select the character for the active digit
    // -------------------------------------------------------------------------
    logic [PW:0]       pos_sum;
    logic [PW-1:0]     strip_idx;
    logic [3:0]        nib_p0;
    logic              blank_p0;
    logic [DIGITS-1:0] digit_bit;

    always_comb begin
        // Strip position shown on digit d: (p + NIBBLES + DIGITS-1 - d) mod L.
        // The sum is below 2L, so a single conditional subtract reduces it.
        pos_sum = {1'b0, p} + POS_OFFSET - {{(PW + 1 - DW){1'b0}}, d};
        if (pos_sum >= STRIP_EXT) begin
            pos_sum = pos_sum - STRIP_EXT;
        end
        strip_idx = pos_sum[PW-1:0];
        digit_bit = DIGITS'(1) << d;

        if (mode) begin
            // Strip entry i holds nibble NIBBLES-1-i; entries past NIBBLES are blank.
            blank_p0 = (strip_idx >= P_NIBBLES);
            nib_p0   = nibble_at(shadow, NIBBLES - 1 - int'(strip_idx));
        end else begin
`ifdef SEG_LZB_EN
            blank_p0 = leading_zero(data, int'(d));
`else
            blank_p0 = 1'b0;
`endif
            nib_p0   = nibble_at(data, int'(d));
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: registered digit enables and segment drives
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '1;
            segments <= 7'h7F;
        end else if (blank_p0) begin
            sel      <= '1;
            segments <= 7'h7F;
        end else begin
            sel      <= ~digit_bit;
            segments <= ~hex_glyph(nib_p0);
        end
    end

endmodule

// File: tb/tb_seg_scroll.sv
// -----------------------------------------------------------------------------
// tb_seg_scroll
//
// Self-checking bench for seg_scroll with DIGITS=4, NIBBLES=8, SCAN_DIV=4,
// SCROLL_DIV=64. A reference model tracks elapsed scan and scroll cycles and
// derives the digit index, scroll position and shown character arithmetically;
// directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_seg_scroll;

    localparam int DIGITS     = 4;
    localparam int NIBBLES    = 8;
    localparam int SCAN_DIV   = 4;
    localparam int SCROLL_DIV = 64;
    localparam int L          = NIBBLES + DIGITS;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data  = 32'h0;
    logic        mode  = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  sel;
    logic [6:0]  segments;
    logic        frame_done;

    seg_scroll #(
        .DIGITS    (DIGITS),
        .NIBBLES   (NIBBLES),
        .SCAN_DIV  (SCAN_DIV),
        .SCROLL_DIV(SCROLL_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .mode      (mode),
        .pause     (pause),
        .sel       (sel),
        .segments  (segments),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          scan_n;      // clock edges since reset release
    int          run_n;       // counted scroll cycles since scrolling (re)started
    logic [31:0] m_shadow;
    logic        m_prev_mode;
    logic        m_first;
    logic [3:0]  e_sel;
    logic [6:0]  e_seg;
    logic        e_fd;

    // Observation helpers
    int seen [DIGITS];
    int lit_n;
    int fd_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cur_d();
        return (scan_n / SCAN_DIV) % DIGITS;
    endfunction

    function automatic int cur_p();
        return (run_n / SCROLL_DIV) % L;
    endfunction

    task automatic model_reset();
        scan_n      = 0;
        run_n       = 0;
        m_shadow    = 32'h0;
        m_prev_mode = 1'b0;
        m_first     = 1'b1;
        e_sel       = 4'hF;
        e_seg       = 7'h7F;
        e_fd        = 1'b0;
    endtask

    // Character shown on digit dd at position pp, derived from the strip.
    task automatic model_display(input int dd, input int pp,
                                 output logic [3:0] s, output logic [6:0] g);
        int strip [L];
        int v;
        int hi;
        for (int i = 0; i < L; i++) begin
            strip[i] = (i < NIBBLES) ? int'(m_shadow[4*(NIBBLES-1-i) +: 4]) : -1;
        end
        if (mode) begin
            v = strip[(pp + NIBBLES + DIGITS - 1 - dd) % L];
        end else begin
            v = int'(data[4*dd +: 4]);
            hi = 0;
`ifdef SEG_LZB_EN
            for (int k = 0; k < DIGITS; k++) begin
                if (data[4*k +: 4] != 4'h0) hi = k;
            end
            if (dd > hi) v = -1;
`endif
        end
        if (v < 0) begin
            s = 4'hF;
            g = 7'h7F;
        end else begin
            s = ~(4'b0001 << dd);
            g = ~GLYPH[v];
        end
    endtask

    task automatic model_step();
        logic rise;
        logic wrap;
        model_display(cur_d(), cur_p(), e_sel, e_seg);
        rise = mode && !m_prev_mode;
        wrap = 1'b0;
        scan_n++;
        if (!mode || rise) begin
            run_n = 0;
        end else if (!pause) begin
            run_n++;
            wrap = ((run_n % (SCROLL_DIV * L)) == 0);
        end
        if (m_first || rise || wrap) m_shadow = data;
        e_fd        = wrap;
        m_prev_mode = mode;
        m_first     = 1'b0;
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        check("sel", sel, e_sel);
        check("segments", segments, e_seg);
        check("frame_done", frame_done, e_fd);
        check("one_lit", ($countones(~sel) <= 1), 1);
        if (frame_done) fd_count++;
    endtask

    task automatic observe(input int n);
        for (int k = 0; k < DIGITS; k++) seen[k] = -1;
        lit_n = 0;
        repeat (n) begin
            cycle();
            if (sel != 4'hF) lit_n++;
            for (int k = 0; k < DIGITS; k++) begin
                if (!sel[k]) seen[k] = int'(segments);
            end
        end
    endtask

    task automatic check_digits(input string tag, input int e3, input int e2,
                                input int e1, input int e0);
        check({tag, "_d3"}, seen[3], e3);
        check({tag, "_d2"}, seen[2], e2);
        check({tag, "_d1"}, seen[1], e1);
        check({tag, "_d0"}, seen[0], e0);
    endtask

    task automatic wait_p(input int target);
        int guard;
        guard = 0;
        while (cur_p() != target && guard < 2000) begin
            cycle();
            guard++;
        end
        check("wait_p_bound", (cur_p() == target), 1);
    endtask

    // Assert reset in the middle of a cycle, check outputs at once, release
    // on the next falling edge.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_sel", sel, 4'hF);
        check("rst_segments", segments, 7'h7F);
        check("rst_frame_done", frame_done, 1'b0);
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        fd_count = 0;

        // Reset and static display
        @(negedge clk);
        mid_reset();
        data = 32'h0000_1A2F;
        observe(20);
        check_digits("static_1a2f", 32'h79, 32'h08, 32'h24, 32'h0E);
        data = 32'h0;
        observe(20);
`ifdef SEG_LZB_EN
        check_digits("static_zero", -1, -1, -1, 32'h40);
`else
        check_digits("static_zero", 32'h40, 32'h40, 32'h40, 32'h40);
`endif

        // Scroll pass of DEADBEEF
        data = 32'hDEAD_BEEF;
        mode = 1'b1;
        observe(20);
        check("p0_dark", lit_n, 0);
        wait_p(1);
        observe(20);
        check_digits("p1", -1, -1, -1, 32'h21);
        wait_p(4);
        observe(20);
        check_digits("p4", 32'h21, 32'h06, 32'h08, 32'h21);
        wait_p(5);
        data = 32'h1234_5678;
        wait_p(8);
        observe(20);
        check_digits("p8", 32'h03, 32'h06, 32'h06, 32'h0E);
        wait_p(11);
        observe(20);
        check_digits("p11", 32'h0E, -1, -1, -1);

        // New shadow after the wrap, one frame pulse per pass
        wait_p(0);
        wait_p(1);
        observe(20);
        check_digits("next_pass_p1", -1, -1, -1, 32'h79);
        fd_count = 0;
        repeat (L * SCROLL_DIV) cycle();
        check("frame_pulses", fd_count, 1);

        // Pause holds the position while the scan keeps running
        wait_p(6);
        pause    = 1'b1;
        fd_count = 0;
        observe(500);
        check_digits("pause_p6", 32'h30, 32'h19, 32'h12, 32'h02);
        check("pause_lit", (lit_n > 400), 1);
        check("pause_no_frame", fd_count, 0);
        pause = 1'b0;
        observe(60);
        check_digits("unpause_p6", 32'h30, 32'h19, 32'h12, 32'h02);
        wait_p(7);

        // Mode changes
        wait_p(9);
        mode = 1'b0;
        data = 32'h9000_00C5;
        observe(20);
`ifdef SEG_LZB_EN
        check_digits("to_static", -1, -1, 32'h46, 32'h12);
`else
        check_digits("to_static", 32'h40, 32'h40, 32'h46, 32'h12);
`endif
        mode = 1'b1;
        observe(20);
        check("restart_dark", lit_n, 0);
        wait_p(1);
        observe(20);
        check_digits("restart_p1", -1, -1, -1, 32'h10);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            if ($urandom_range(0, 99) == 0)  pause = ~pause;
            if ($urandom_range(0, 49) == 0)  data = $urandom;
            if (i == 2500) begin
                mode  = 1'b1;
                pause = 1'b0;
                mid_reset();
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
